// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file scoreboard slice.
// Build option REGFILE_BYPASS_EN (see regfile_scoreboard.sv) enables write-to-read forwarding.
package regfile_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Low bit of port `port` in a flat bus of `width`-bit fields.
  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy bits plus a registered popcount, updated together each edge.
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int ZERO_REG = 1,
  localparam int DEPTH = depth_of(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   busy_count
);

  logic [DEPTH-1:0] next_busy;
  logic             set_ok;
  logic             inc;
  logic             dec;

  // A set and clear on the same register resolve to set: the new producer wins.
  always_comb begin
    next_busy = busy;
    set_ok    = set_en && !((ZERO_REG != 0) && (set_addr == '0));
    if (clr_en) next_busy[clr_addr] = 1'b0;
    if (set_ok) next_busy[set_addr] = 1'b1;
    inc = set_ok && !busy[set_addr];
    dec = clr_en && busy[clr_addr] && !(set_ok && (set_addr == clr_addr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy <= next_busy;
      case ({inc, dec})
        2'b10:   busy_count <= busy_count + (ADDR_W+1)'(1);
        2'b01:   busy_count <= busy_count - (ADDR_W+1)'(1);
        default: busy_count <= busy_count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with busy scoreboard and a post-reset clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to matching read ports.
//
// Handshake: there is no back-pressure. issue_en/wr_en are single-cycle strobes accepted
// on every rising edge while ready=1 and dropped while ready=0; reads are combinational.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [ADDR_W:0]          busy_count,
  output logic [0:0]               state_dbg
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DEPTH-1:0]  busy;
  logic              run;

  assign run       = (state == ST_RUN);
  assign ready     = run;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      clr_ptr <= '0;
    end else if (state == ST_INIT) begin
      clr_ptr <= clr_ptr + ADDR_W'(1);
      if (clr_ptr == '1) state <= ST_RUN;
    end
  end

  // Storage carries no reset of its own; the sweep clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT)
        regs[clr_ptr] <= '0;
      else if (wr_en && !((ZERO_REG != 0) && (wr_addr == '0)))
        regs[wr_addr] <= wr_data;
    end
  end

  regfile_busy_tracker #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk        (clk),
    .rst        (rst),
    .set_en     (run && issue_en),
    .set_addr   (issue_addr),
    .clr_en     (run && wr_en),
    .clr_addr   (wr_addr),
    .busy       (busy),
    .busy_count (busy_count)
  );

  always_comb begin : rd_mux
    logic [ADDR_W-1:0] a;
    a       = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = rd_addr[port_lo(i, ADDR_W) +: ADDR_W];
      if (run && !((ZERO_REG != 0) && (a == '0))) begin
        rd_data[port_lo(i, DATA_W) +: DATA_W] = regs[a];
        rd_busy[i] = busy[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == a)) begin
          rd_data[port_lo(i, DATA_W) +: DATA_W] = wr_data;
          rd_busy[i] = issue_en && (issue_addr == a);
        end
`endif
      end
    end
  end

endmodule
